key_note_tracker: RTL

Polyphonic successor to the single-key ASCII-to-note decoder used by the keyboard piano. It accepts key press/release events from the keyboard front end, decodes each ASCII key to a 14-entry note index, and allocates it to one of CHANNELS voice slots. It also tracks a saturating octave register and latches the current octave into the slot at press time. Its outputs drive the per-channel tone generators and the seven-segment note display.

---
 rtl/piano_pkg.sv | 29 ++
 rtl/key2note.sv | 33 +++
 rtl/key_note_tracker.sv | 109 ++++++++++
 3 files changed

// File: rtl/piano_pkg.sv
// Shared note definitions for the keyboard piano: note index width,
// named note indices and the decode-miss encoding.
package piano_pkg;

    localparam int NOTE_W    = 4;
    localparam int NUM_NOTES = 14;

    // Note indices: lower-case keys are the fourth octave, upper-case the fifth.
    typedef enum logic [NOTE_W-1:0] {
        NOTE_C4 = 4'd0,
        NOTE_D4 = 4'd1,
        NOTE_E4 = 4'd2,
        NOTE_F4 = 4'd3,
        NOTE_G4 = 4'd4,
        NOTE_A4 = 4'd5,
        NOTE_B4 = 4'd6,
        NOTE_C5 = 4'd7,
        NOTE_D5 = 4'd8,
        NOTE_E5 = 4'd9,
        NOTE_F5 = 4'd10,
        NOTE_G5 = 4'd11,
        NOTE_A5 = 4'd12,
        NOTE_B5 = 4'd13
    } note_e;

    // Decode result {hit, index}; a miss has the hit flag clear and index 0.
    localparam logic [NOTE_W:0] UNMAPPED = {1'b0, {NOTE_W{1'b0}}};

endpackage

// File: rtl/key2note.sv
// Combinational ASCII key to note-index decoder, shared with the display path.
module key2note
    import piano_pkg::*;
(
    input  logic [7:0]        key_code,
    output logic              hit,
    output logic [NOTE_W-1:0] index
);

    // Map the fourteen piano keys onto note indices; anything else misses.
    always_comb begin
        // NOTE: default every combinational output first so no path infers a latch.
        {hit, index} = UNMAPPED;
        case (key_code)
            8'd99:  {hit, index} = {1'b1, NOTE_C4};
            8'd100: {hit, index} = {1'b1, NOTE_D4};
            8'd101: {hit, index} = {1'b1, NOTE_E4};
            8'd102: {hit, index} = {1'b1, NOTE_F4};
            8'd103: {hit, index} = {1'b1, NOTE_G4};
            8'd97:  {hit, index} = {1'b1, NOTE_A4};
            8'd98:  {hit, index} = {1'b1, NOTE_B4};
            8'd67:  {hit, index} = {1'b1, NOTE_C5};
            8'd68:  {hit, index} = {1'b1, NOTE_D5};
            8'd69:  {hit, index} = {1'b1, NOTE_E5};
            8'd70:  {hit, index} = {1'b1, NOTE_F5};
            8'd71:  {hit, index} = {1'b1, NOTE_G5};
            8'd65:  {hit, index} = {1'b1, NOTE_A5};
            8'd66:  {hit, index} = {1'b1, NOTE_B5};
            default: {hit, index} = UNMAPPED;
        endcase
    end

endmodule

// File: rtl/key_note_tracker.sv
// Polyphonic key tracker: allocates pressed notes to voice slots, frees them
// on release, and keeps a saturating octave register latched per slot.
module key_note_tracker
    import piano_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int OCT_W       = 3,
    parameter int OCT_DEFAULT = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         key_valid,
    input  logic [7:0]                   key_code,
    input  logic                         key_release,
    input  logic                         octave_up,
    input  logic                         octave_down,
    output logic [CHANNELS*NOTE_W-1:0]   note,
    output logic [CHANNELS*OCT_W-1:0]    note_oct,
    output logic [CHANNELS-1:0]          note_active,
    output logic [OCT_W-1:0]             octave,
    output logic                         drop,
    output logic                         unmapped
);

    localparam logic [OCT_W-1:0] OCT_MAX   = {OCT_W{1'b1}};
    localparam logic [OCT_W-1:0] OCT_ONE   = OCT_W'(1);
    localparam logic [OCT_W-1:0] OCT_RESET = OCT_W'(OCT_DEFAULT);

    logic              key_hit;
    logic [NOTE_W-1:0] key_index;

    logic [CHANNELS-1:0] held_match;
    logic [CHANNELS-1:0] free_onehot;
    logic                any_free;

    logic press_evt;
    logic release_evt;

    key2note u_key2note (
        .key_code (key_code),
        .hit      (key_hit),
        .index    (key_index)
    );

    assign press_evt   = key_valid && !key_release;
    assign release_evt = key_valid &&  key_release;

    // Flag slots already holding the event note, and pick the lowest free slot.
    always_comb begin
        held_match  = '0;
        free_onehot = '0;
        any_free    = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            held_match[i] = note_active[i] && (note[i*NOTE_W +: NOTE_W] == key_index);
            if (!note_active[i] && !any_free) begin
                free_onehot[i] = 1'b1;
                any_free       = 1'b1;
            end
        end
    end

    // Slot state, status pulses and the octave register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the slot registers are small flops feeding the tone generators,
            // so they are cleared on reset like any other control state.
            note        <= '0;
            note_oct    <= '0;
            note_active <= '0;
            octave      <= OCT_RESET;
            drop        <= 1'b0;
            unmapped    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading the
            // pre-edge values, so a press latches the octave before its update.
            drop     <= 1'b0;
            unmapped <= 1'b0;

            if (press_evt) begin
                if (!key_hit) begin
                    unmapped <= 1'b1;
                end else if (held_match == '0) begin
                    if (any_free) begin
                        for (int i = 0; i < CHANNELS; i++) begin
                            if (free_onehot[i]) begin
                                note[i*NOTE_W +: NOTE_W]  <= key_index;
                                note_oct[i*OCT_W +: OCT_W] <= octave;
                                note_active[i]            <= 1'b1;
                            end
                        end
                    end else begin
                        drop <= 1'b1;
                    end
                end
            end

            if (release_evt && key_hit) begin
                note_active <= note_active & ~held_match;
            end

            if (octave_up && !octave_down && octave != OCT_MAX) begin
                octave <= octave + OCT_ONE;
            end else if (octave_down && !octave_up && octave != '0) begin
                octave <= octave - OCT_ONE;
            end
        end
    end

endmodule
